gat_load_sched: RTL and testbench

Sequencer that sits in front of the GAT top-level block. It takes a single 32-bit input word stream and loads the four GAT input BRAMs in a fixed order: H data, H node info, weights, subgraph indices. It drives the per-BRAM load-done flags, waits for `gat_ready`, then reads the result feature BRAM and emits its contents as a 32-bit output stream. It is the only writer of the input BRAMs and the only reader of the feature BRAM.

---
 rtl/gat_load_sched.sv | 213 +++++++++++++++++++++
 tb/tb_gat_load_sched.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gat_load_sched.sv
// Loads the four GAT input BRAMs from one word stream, then streams the feature BRAM back out.
// Writes land 1 cycle after each handshake; readback costs RD_LAT+2 cycles per word and holds out_data until out_ready.
module gat_load_sched #(
   parameter int ADDR_W = 20,
   parameter int LEN_W  = 20,
   parameter int RD_LAT = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [LEN_W-1:0]  len_hdata,
   input  logic [LEN_W-1:0]  len_ninfo,
   input  logic [LEN_W-1:0]  len_wgt,
   input  logic [LEN_W-1:0]  len_subg,
   input  logic [LEN_W-1:0]  len_feat,
   input  logic [31:0]       in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [31:0]       bram_din,
   output logic [ADDR_W-1:0] bram_addra,
   output logic              hdata_ena,
   output logic              hdata_wea,
   output logic              ninfo_ena,
   output logic              ninfo_wea,
   output logic              wgt_ena,
   output logic              wgt_wea,
   output logic              subg_ena,
   output logic              subg_wea,
   output logic              h_data_bram_load_done,
   output logic              h_node_info_bram_load_done,
   output logic              wgt_bram_load_done,
   output logic              subg_load_done,
   input  logic              gat_ready,
   output logic [ADDR_W-1:0] feat_addrb,
   input  logic [31:0]       feat_dout,
   output logic [31:0]       out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);

   typedef enum logic [3:0] {
      IDLE, LD_HDATA, LD_NINFO, LD_WGT, LD_SUBG,
      WAIT_GAT, RD_ISSUE, RD_WAIT, RD_HOLD, DONE
   } state_t;

   localparam int WC_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

   state_t                  state, state_nxt;
   logic [3:0][LEN_W-1:0]   len_in, len_ld;
   logic [LEN_W-1:0]        len_feat_r, len_cur;
   logic [LEN_W-1:0]        wcnt, wcnt_inc, rdcnt, rdcnt_inc;
   logic [WC_W-1:0]         wait_cnt;
   logic [3:0]              nz_in, nz_lat;
   logic [3:0]              load_done, flag_set, wr_en_r;
   logic [2:0]              cur_rg;
   logic                    ld_state, accept, last_beat, start_ok, wait_last, done_r;

   // Region index 4 means "no region left": the loader hands over to WAIT_GAT.
   function automatic logic [2:0] first_nz(input logic [3:0] nz, input logic [2:0] from);
      logic [2:0] r;
      r = 3'd4;
      for (int i = 3; i >= 0; i--)
         if (nz[i] && (3'(i) >= from)) r = 3'(i);
      return r;
   endfunction

   function automatic logic [3:0] skip_mask(input logic [3:0] nz, input logic [2:0] from);
      logic [3:0] m;
      logic [2:0] stop;
      m    = '0;
      stop = first_nz(nz, from);
      for (int i = 0; i < 4; i++)
         if ((3'(i) >= from) && (3'(i) < stop)) m[i] = 1'b1;
      return m;
   endfunction

   function automatic state_t region_state(input logic [2:0] r);
      case (r)
         3'd0:    return LD_HDATA;
         3'd1:    return LD_NINFO;
         3'd2:    return LD_WGT;
         3'd3:    return LD_SUBG;
         default: return WAIT_GAT;
      endcase
   endfunction

   assign len_in = {len_subg, len_wgt, len_ninfo, len_hdata};

   always_comb begin
      for (int i = 0; i < 4; i++) begin
         nz_in[i]  = |len_in[i];
         nz_lat[i] = |len_ld[i];
      end
   end

   always_comb begin
      case (state)
         LD_HDATA: cur_rg = 3'd0;
         LD_NINFO: cur_rg = 3'd1;
         LD_WGT:   cur_rg = 3'd2;
         LD_SUBG:  cur_rg = 3'd3;
         default:  cur_rg = 3'd0;
      endcase
   end

   assign ld_state  = (state == LD_HDATA) || (state == LD_NINFO) ||
                      (state == LD_WGT)   || (state == LD_SUBG);
   assign len_cur   = len_ld[cur_rg[1:0]];
   assign wcnt_inc  = wcnt + 1'b1;
   assign rdcnt_inc = rdcnt + 1'b1;
   assign accept    = in_valid && ld_state;
   assign last_beat = accept && (wcnt_inc == len_cur);
   assign start_ok  = start && ((state == IDLE) || (state == DONE));
   assign wait_last = (wait_cnt == WC_W'(RD_LAT - 1));

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      flag_set  = '0;
      case (state)
         IDLE, DONE: begin
            if (start) begin
               state_nxt = region_state(first_nz(nz_in, 3'd0));
               flag_set  = skip_mask(nz_in, 3'd0);
            end
         end
         LD_HDATA, LD_NINFO, LD_WGT, LD_SUBG: begin
            // Trailing zero-length regions complete together with this one.
            if (last_beat) begin
               state_nxt = region_state(first_nz(nz_lat, cur_rg + 3'd1));
               flag_set  = (4'b1 << cur_rg[1:0]) | skip_mask(nz_lat, cur_rg + 3'd1);
            end
         end
         WAIT_GAT: begin
            if (gat_ready) state_nxt = (len_feat_r == '0) ? DONE : RD_ISSUE;
         end
         RD_ISSUE: state_nxt = RD_WAIT;
         RD_WAIT: begin
            if (wait_last) state_nxt = RD_HOLD;
         end
         RD_HOLD: begin
            if (out_ready) state_nxt = (rdcnt_inc == len_feat_r) ? DONE : RD_ISSUE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         len_ld     <= '0;
         len_feat_r <= '0;
         wcnt       <= '0;
         rdcnt      <= '0;
         wait_cnt   <= '0;
         load_done  <= '0;
         wr_en_r    <= '0;
         bram_din   <= '0;
         bram_addra <= '0;
         feat_addrb <= '0;
         out_data   <= '0;
         done_r     <= 1'b0;
      end else begin
         wr_en_r   <= '0;
         load_done <= (start_ok ? 4'b0 : load_done) | flag_set;
         done_r    <= (state_nxt == DONE) && (state != DONE);
         if (start_ok) begin
            len_ld     <= len_in;
            len_feat_r <= len_feat;
            wcnt       <= '0;
            rdcnt      <= '0;
         end
         if (accept) begin
            wr_en_r    <= 4'b1 << cur_rg[1:0];
            bram_din   <= in_data;
            bram_addra <= ADDR_W'(wcnt) << 2;
            wcnt       <= last_beat ? '0 : wcnt_inc;
         end
         if (state == RD_WAIT) wait_cnt <= wait_cnt + 1'b1;
         else                  wait_cnt <= '0;
         if ((state == RD_WAIT) && wait_last) out_data <= feat_dout;
         if ((state == RD_HOLD) && out_ready) rdcnt <= rdcnt_inc;
         // The address is registered on entry so it is already on the port during RD_ISSUE.
         if ((state_nxt == RD_ISSUE) && (state != RD_ISSUE))
            feat_addrb <= ADDR_W'((state == RD_HOLD) ? rdcnt_inc : rdcnt) << 2;
      end
   end

   assign in_ready  = ld_state;
   assign out_valid = (state == RD_HOLD);
   assign busy      = (state != IDLE) && (state != DONE);
   assign done      = done_r;

   assign hdata_ena = wr_en_r[0];
   assign hdata_wea = wr_en_r[0];
   assign ninfo_ena = wr_en_r[1];
   assign ninfo_wea = wr_en_r[1];
   assign wgt_ena   = wr_en_r[2];
   assign wgt_wea   = wr_en_r[2];
   assign subg_ena  = wr_en_r[3];
   assign subg_wea  = wr_en_r[3];

   assign h_data_bram_load_done      = load_done[0];
   assign h_node_info_bram_load_done = load_done[1];
   assign wgt_bram_load_done         = load_done[2];
   assign subg_load_done             = load_done[3];

endmodule

// File: tb/tb_gat_load_sched.sv
// Scoreboard bench for gat_load_sched: write and readback expectations are queued when stimulus is driven.
module tb_gat_load_sched;

   localparam int RD_LAT = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic [19:0] len_hdata = '0, len_ninfo = '0, len_wgt = '0, len_subg = '0, len_feat = '0;
   logic [31:0] in_data = '0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] bram_din;
   logic [19:0] bram_addra;
   logic        hdata_ena, hdata_wea, ninfo_ena, ninfo_wea, wgt_ena, wgt_wea, subg_ena, subg_wea;
   logic        h_data_bram_load_done, h_node_info_bram_load_done, wgt_bram_load_done, subg_load_done;
   logic        gat_ready = 1'b0;
   logic [19:0] feat_addrb;
   logic [31:0] feat_dout;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic        busy, done;

   gat_load_sched #(.ADDR_W(20), .LEN_W(20), .RD_LAT(RD_LAT)) dut (
      .clk(clk), .rst(rst), .start(start),
      .len_hdata(len_hdata), .len_ninfo(len_ninfo), .len_wgt(len_wgt),
      .len_subg(len_subg), .len_feat(len_feat),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .bram_din(bram_din), .bram_addra(bram_addra),
      .hdata_ena(hdata_ena), .hdata_wea(hdata_wea), .ninfo_ena(ninfo_ena), .ninfo_wea(ninfo_wea),
      .wgt_ena(wgt_ena), .wgt_wea(wgt_wea), .subg_ena(subg_ena), .subg_wea(subg_wea),
      .h_data_bram_load_done(h_data_bram_load_done),
      .h_node_info_bram_load_done(h_node_info_bram_load_done),
      .wgt_bram_load_done(wgt_bram_load_done), .subg_load_done(subg_load_done),
      .gat_ready(gat_ready), .feat_addrb(feat_addrb), .feat_dout(feat_dout),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  rg;
      logic [19:0] addr;
      logic [31:0] dat;
   } wr_t;

   wr_t         wrq[$];
   logic [31:0] rdq[$];
   int          n_vec = 0;
   int          n_err = 0;
   int          cyc = 0;
   int          done_cnt = 0;
   int          rise[4];
   int          last_wr[4];
   int          lens_m[4];
   int          m_rg, m_cnt;
   logic [3:0]  flags, flags_q = '0, ena, wea;
   logic [31:0] fmem[8];
   logic [31:0] p1 = '0, p2 = '0;

   assign flags = {subg_load_done, wgt_bram_load_done, h_node_info_bram_load_done, h_data_bram_load_done};
   assign ena   = {subg_ena, wgt_ena, ninfo_ena, hdata_ena};
   assign wea   = {subg_wea, wgt_wea, ninfo_wea, hdata_wea};

   // Feature BRAM with two-cycle read latency.
   always @(posedge clk) begin
      p1 <= fmem[feat_addrb[4:2]];
      p2 <= p1;
   end
   assign feat_dout = p2;

   task automatic chk_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
      end
   endtask

   always @(negedge clk) begin
      wr_t e;
      cyc++;
      if (ena != 4'b0) begin
         chk_eq("wr_wea", 64'(wea), 64'(ena));
         chk_eq("wr_onehot", 64'($countones(ena)), 64'd1);
         if (wrq.size() == 0) chk_eq("wr_extra", 64'(ena), 64'd0);
         else begin
            e = wrq.pop_front();
            chk_eq("wr_rg", 64'(ena), 64'(4'b1 << e.rg));
            chk_eq("wr_addr", 64'(bram_addra), 64'(e.addr));
            chk_eq("wr_data", 64'(bram_din), 64'(e.dat));
         end
      end
      for (int r = 0; r < 4; r++) begin
         if (ena[r]) last_wr[r] = cyc;
         if (flags[r] && !flags_q[r]) rise[r] = cyc;
      end
      flags_q = flags;
      if (out_valid) begin
         if (rdq.size() == 0) chk_eq("rd_extra", 64'd1, 64'd0);
         else begin
            chk_eq("rd_data", 64'(out_data), 64'(rdq[0]));
            if (out_ready) void'(rdq.pop_front());
         end
      end
      if (done) done_cnt++;
   end

   task automatic push_model(input logic [31:0] d);
      wrq.push_back('{rg: 2'(m_rg), addr: 20'(m_cnt * 4), dat: d});
      m_cnt++;
      if (m_cnt == lens_m[m_rg]) begin
         m_cnt = 0;
         m_rg++;
         while (m_rg < 4 && lens_m[m_rg] == 0) m_rg++;
      end
   endtask

   task automatic start_job(input int l0, input int l1, input int l2, input int l3, input int lf);
      lens_m = '{l0, l1, l2, l3};
      m_rg = 0;
      m_cnt = 0;
      while (m_rg < 4 && lens_m[m_rg] == 0) m_rg++;
      done_cnt = 0;
      for (int r = 0; r < 4; r++) begin
         rise[r] = -1;
         last_wr[r] = -1;
      end
      len_hdata = 20'(l0); len_ninfo = 20'(l1); len_wgt = 20'(l2); len_subg = 20'(l3); len_feat = 20'(lf);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic feed(input int cnt, input logic [31:0] base, input int gap, input bit wgt_start);
      int k = 0;
      int c = 0;
      bit pulsed = 1'b0;
      while (k < cnt && c < 300) begin
         @(posedge clk); #1;
         start = 1'b0;
         if (wgt_start && !pulsed && m_rg == 2) begin
            start = 1'b1;
            pulsed = 1'b1;
            len_hdata = 20'd5; len_ninfo = 20'd5; len_wgt = 20'd5; len_subg = 20'd5; len_feat = 20'd5;
         end
         in_valid = (gap == 0) || (c % 3 == 0);
         in_data  = base + 32'(k);
         @(negedge clk);
         if (in_valid && in_ready) begin
            push_model(in_data);
            k++;
         end
         c++;
      end
      chk_eq("feed_cnt", 64'(k), 64'(cnt));
      @(posedge clk); #1;
      in_valid = 1'b0;
      start = 1'b0;
   endtask

   task automatic run_job(input int l0, input int l1, input int l2, input int l3, input int lf,
                          input logic [31:0] base, input int gap, input bit wgt_start, input int hold);
      int n;
      start_job(l0, l1, l2, l3, lf);
      feed(l0 + l1 + l2 + l3, base, gap, wgt_start);
      repeat (2) @(negedge clk);
      chk_eq("flags_loaded", 64'(flags), 64'hF);
      chk_eq("wrq_left", 64'(wrq.size()), 64'd0);
      chk_eq("busy_wait", 64'(busy), 64'd1);
      for (int r = 0; r < 4; r++)
         if (lens_m[r] != 0) chk_eq($sformatf("flag_rise_%0d", r), 64'(rise[r]), 64'(last_wr[r]));
      repeat (5) @(posedge clk);
      #1;
      for (int i = 0; i < lf; i++) rdq.push_back(fmem[i]);
      gat_ready = 1'b1;
      if (lf > 0) begin
         n = 0;
         forever begin
            @(negedge clk);
            if (out_valid || n >= 50) break;
            n++;
         end
         chk_eq("rd_lat", 64'(n), 64'(RD_LAT + 2));
         repeat (hold) @(posedge clk);
         #1;
         out_ready = 1'b1;
      end
      n = 0;
      while (done_cnt == 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk_eq("done_seen", 64'(done_cnt > 0), 64'd1);
      @(posedge clk); #1;
      gat_ready = 1'b0;
      out_ready = 1'b0;
      repeat (3) @(negedge clk);
      chk_eq("done_once", 64'(done_cnt), 64'd1);
      chk_eq("rdq_left", 64'(rdq.size()), 64'd0);
      chk_eq("busy_end", 64'(busy), 64'd0);
      chk_eq("flags_keep", 64'(flags), 64'hF);
      @(posedge clk); #1;
   endtask

   initial begin
      for (int i = 0; i < 8; i++) fmem[i] = 32'hA0 + 32'(i);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      chk_eq("rst_ctl", 64'({in_ready, ena, flags, out_valid, busy, done}), 64'd0);
      chk_eq("rst_addr", 64'({feat_addrb, bram_addra}), 64'd0);
      chk_eq("rst_out_data", 64'(out_data), 64'd0);
      @(posedge clk); #1;

      run_job(3, 2, 2, 1, 2, 32'h100, 0, 1'b0, 4);

      run_job(2, 0, 2, 1, 2, 32'h300, 0, 1'b0, 1);
      chk_eq("ninfo_rise", 64'(rise[1]), 64'(rise[0]));
      chk_eq("ninfo_nowr", 64'(last_wr[1]), 64'(-1));

      run_job(3, 2, 2, 1, 2, 32'h400, 1, 1'b0, 1);

      start_job(2, 2, 2, 1, 2);
      feed(2, 32'h600, 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk_eq("pre_rst_flag", 64'(flags), 64'h1);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk_eq("rst_mid_ctl", 64'({in_ready, ena, flags, busy}), 64'd0);
      chk_eq("rst_mid_wrq", 64'(wrq.size()), 64'd0);
      @(posedge clk); #1;
      run_job(3, 2, 2, 1, 2, 32'h200, 0, 1'b0, 2);

      run_job(3, 2, 2, 1, 2, 32'h500, 0, 1'b1, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
